// File: rtl/flash_seq_pkg.sv
// flash_seq_pkg: shared constants and state encoding for the flasher sequencer.
package flash_seq_pkg;

  localparam int MX_LP   = 16;
  localparam int KB_PT_1 = 5;
  localparam int CNT_W   = 8;
  localparam int WDOG    = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    NEXT  = 3'd3,
    FIN   = 3'd4
  } flash_seq_st_e;

endpackage

// File: rtl/flash_seq_ctl_if.sv
// flash_seq_ctl_if: host-side command/status bundle of the flasher sequencer.
interface flash_seq_ctl_if #(
  parameter int CNT_W = flash_seq_pkg::CNT_W
);

  logic             cmd_vld;
  logic             cmd_rdy;
  logic [CNT_W-1:0] cmd_rpt;
  logic             cmd_kick;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] run_cnt;

  modport master (
    output cmd_vld, cmd_rpt, cmd_kick, abort,
    input  cmd_rdy, busy, done, err, run_cnt
  );

  modport slave (
    input  cmd_vld, cmd_rpt, cmd_kick, abort,
    output cmd_rdy, busy, done, err, run_cnt
  );

endinterface

// File: rtl/flash_seq_ctl_lp_mon.sv
// lp_mon: registers the lamp vector and produces registered one-cycle event
// strobes (lp[0] rise, run end, kickback crossing, any change).
module lp_mon #(
  parameter int MX_LP   = flash_seq_pkg::MX_LP,
  parameter int KB_PT_1 = flash_seq_pkg::KB_PT_1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MX_LP-1:0] lp,
  output logic             lp0_rise,
  output logic             run_end,
  output logic             kb_hit,
  output logic             lp_chg
);

  import flash_seq_pkg::*;

  logic [MX_LP-1:0] lp_q;

  // Compare the current lamps with last cycle's and register the events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_q     <= '0;
      lp0_rise <= 1'b0;
      run_end  <= 1'b0;
      kb_hit   <= 1'b0;
      lp_chg   <= 1'b0;
    end else begin
      lp_q     <= lp;
      lp0_rise <= lp[0] & ~lp_q[0];
      run_end  <= (lp == '0) && (lp_q != '0);
      kb_hit   <= lp_q[KB_PT_1] & ~lp[KB_PT_1] & lp[KB_PT_1-1];
      lp_chg   <= (lp != lp_q);
    end
  end

endmodule

// File: rtl/flash_seq_ctl.sv
// flash_seq_ctl: run sequencer for the bound-flasher lamp datapath.
// Optional stall watchdog compiled in with macro FLASH_SEQ_WDOG_EN.
module flash_seq_ctl #(
  parameter int MX_LP   = flash_seq_pkg::MX_LP,
  parameter int KB_PT_1 = flash_seq_pkg::KB_PT_1,
  parameter int CNT_W   = flash_seq_pkg::CNT_W,
  parameter int WDOG    = flash_seq_pkg::WDOG
) (
  input  logic             clk,
  input  logic             rst_n,
  flash_seq_ctl_if.slave   host,
  input  logic [MX_LP-1:0] lp,
  output logic             flick
);

  import flash_seq_pkg::*;

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_NEXT  = NEXT;
  localparam logic [2:0] S_FIN   = FIN;

  logic [2:0]       state;
  logic [CNT_W-1:0] rpt_q;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W:0]   run_inc;
  logic             kick_q;
  logic             kb_used;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             lp0_rise;
  logic             run_end;
  logic             kb_hit;
  logic             lp_chg;
  logic             wdog_hit;

  lp_mon #(
    .MX_LP   (MX_LP),
    .KB_PT_1 (KB_PT_1)
  ) u_lp_mon (
    .clk      (clk),
    .rst_n    (rst_n),
    .lp       (lp),
    .lp0_rise (lp0_rise),
    .run_end  (run_end),
    .kb_hit   (kb_hit),
    .lp_chg   (lp_chg)
  );

  assign run_inc      = {1'b0, run_cnt} + (CNT_W+1)'(1);
  assign host.cmd_rdy = (state == S_IDLE);
  assign host.busy    = busy_r;
  assign host.done    = done_r;
  assign host.err     = err_r;
  assign host.run_cnt = run_cnt;

`ifdef FLASH_SEQ_WDOG_EN
  logic [15:0] wdog_cnt;

  assign wdog_hit = ((state == S_START) || (state == S_RUN)) && !lp_chg &&
                    (wdog_cnt == 16'(WDOG - 1));

  // Count cycles with unchanged lamps while a run is in flight; zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (((state == S_START) || (state == S_RUN)) && !lp_chg) begin
      wdog_cnt <= wdog_cnt + 16'd1;
    end else begin
      wdog_cnt <= '0;
    end
  end
`else
  logic unused_wdog;

  assign wdog_hit    = 1'b0;
  assign unused_wdog = lp_chg ^ (WDOG > 0);
`endif

  // Main sequencer: command accept, flick drive, run counting and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      flick   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      run_cnt <= '0;
      rpt_q   <= '0;
      kick_q  <= 1'b0;
      kb_used <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (host.abort && (state != S_IDLE)) begin
        state  <= S_IDLE;
        flick  <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (host.cmd_vld) begin
              rpt_q   <= host.cmd_rpt;
              kick_q  <= host.cmd_kick;
              run_cnt <= '0;
              err_r   <= 1'b0;
              busy_r  <= 1'b1;
              kb_used <= 1'b0;
              if (host.cmd_rpt == '0) begin
                state  <= S_FIN;
                done_r <= 1'b1;
              end else begin
                state <= S_START;
                flick <= 1'b1;
              end
            end
          end
          S_START: begin
            if (lp0_rise) begin
              state <= S_RUN;
              flick <= 1'b0;
            end else if (wdog_hit) begin
              state  <= S_IDLE;
              flick  <= 1'b0;
              busy_r <= 1'b0;
              err_r  <= 1'b1;
            end
          end
          S_RUN: begin
            flick <= 1'b0;
            if (run_end) begin
              state <= S_NEXT;
            end else if (wdog_hit) begin
              state  <= S_IDLE;
              busy_r <= 1'b0;
              err_r  <= 1'b1;
            end else if (kick_q && !kb_used && kb_hit) begin
              flick   <= 1'b1;
              kb_used <= 1'b1;
            end
          end
          S_NEXT: begin
            if (!(&run_cnt)) begin
              run_cnt <= run_cnt + CNT_W'(1);
            end
            if (run_inc == {1'b0, rpt_q}) begin
              state  <= S_FIN;
              done_r <= 1'b1;
            end else begin
              state   <= S_START;
              flick   <= 1'b1;
              kb_used <= 1'b0;
            end
          end
          S_FIN: begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            flick  <= 1'b0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_seq_ctl.sv
// tb_flash_seq_ctl: directed commands against a simple bound-flasher model;
// expected completions are queued and checked by an independent monitor.
module tb_flash_seq_ctl;

  import flash_seq_pkg::*;

  typedef struct {
    int run_cnt;
    int err;
    int fl_cycles;
    int fl_bursts;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] lp = '0;
  logic        flick;

  flash_seq_ctl_if #(.CNT_W(8)) bus();

  flash_seq_ctl #(
    .MX_LP   (16),
    .KB_PT_1 (5),
    .CNT_W   (8),
    .WDOG    (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bus),
    .lp    (lp),
    .flick (flick)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Flasher model: on flick from idle, light lamps upward to all-on, then
  // extinguish downward; a flick during the downward sweep re-lights upward.
  int          phase = 0;
  logic        hold_en = 1'b0;
  logic [15:0] hold_val = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      lp = '0;
      phase = 0;
    end else if (hold_en) begin
      lp = hold_val;
      phase = 0;
    end else begin
      case (phase)
        0: if (flick) begin lp = 16'h0001; phase = 1; end
        1: begin
          lp = {lp[14:0], 1'b1};
          if (lp == 16'hFFFF) phase = 2;
        end
        default: begin
          if (flick) begin
            lp = {lp[14:0], 1'b1};
            phase = 1;
          end else begin
            lp = lp >> 1;
            if (lp == 16'h0000) phase = 0;
          end
        end
      endcase
    end
  end

  // Monitor: counts flick activity per command and checks each done pulse.
  int   fl_cycles = 0;
  int   fl_bursts = 0;
  logic busy_prev = 1'b0;
  logic flick_prev = 1'b0;
  logic post_done = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (post_done) begin
        checkOutput("done_width", bus.done, 0);
        checkOutput("busy_after_done", bus.busy, 0);
        post_done = 1'b0;
      end
      if (bus.busy && !busy_prev) begin
        fl_cycles = 0;
        fl_bursts = 0;
      end
      if (flick) fl_cycles++;
      if (flick && !flick_prev) fl_bursts++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL done_unexpected actual=1 required=0");
        end else begin
          e = sb.pop_front();
          checkOutput("sb_run_cnt", bus.run_cnt, e.run_cnt);
          checkOutput("sb_err", bus.err, e.err);
          checkOutput("sb_flick_cycles", fl_cycles, e.fl_cycles);
          checkOutput("sb_flick_bursts", fl_bursts, e.fl_bursts);
          post_done = 1'b1;
        end
      end
      busy_prev = bus.busy;
      flick_prev = flick;
    end
  end

  task automatic applyStimulus(input int rpt, input bit kick, input bit expect_done, input exp_t ex);
    if (expect_done) sb.push_back(ex);
    @(negedge clk);
    bus.cmd_rpt  = rpt[7:0];
    bus.cmd_kick = kick;
    bus.cmd_vld  = 1'b1;
    @(negedge clk);
    bus.cmd_vld  = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, bus.busy, 0);
  endtask

  task automatic pulseAbort();
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  task automatic clearModel();
    hold_val = '0;
    hold_en = 1'b1;
    repeat (5) @(negedge clk);
    hold_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Bound on the total run time.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    bus.cmd_vld  = 1'b0;
    bus.cmd_rpt  = '0;
    bus.cmd_kick = 1'b0;
    bus.abort    = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_flick", flick, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err", bus.err, 0);
    checkOutput("rst_run_cnt", bus.run_cnt, 0);
    checkOutput("rst_cmd_rdy", bus.cmd_rdy, 1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idle_flick", flick, 0);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_done", bus.done, 0);
    checkOutput("idle_err", bus.err, 0);
    checkOutput("idle_run_cnt", bus.run_cnt, 0);
    checkOutput("idle_cmd_rdy", bus.cmd_rdy, 1);

    $display("[TB] two runs, no kickback");
    applyStimulus(2, 1'b0, 1'b1, '{2, 0, 4, 2});
    checkOutput("rpt2_busy_after_accept", bus.busy, 1);
    checkOutput("rpt2_flick_after_accept", flick, 1);
    checkOutput("rpt2_cmd_rdy_busy", bus.cmd_rdy, 0);
    waitIdle("rpt2_idle_timeout", 400);
    checkOutput("rpt2_run_cnt", bus.run_cnt, 2);
    repeat (3) @(negedge clk);

    $display("[TB] one run with kickback");
    applyStimulus(1, 1'b1, 1'b1, '{1, 0, 3, 2});
    waitIdle("kick_idle_timeout", 400);
    checkOutput("kick_run_cnt", bus.run_cnt, 1);
    repeat (3) @(negedge clk);

    $display("[TB] zero-run command");
    applyStimulus(0, 1'b0, 1'b1, '{0, 0, 0, 0});
    checkOutput("rpt0_done", bus.done, 1);
    checkOutput("rpt0_flick", flick, 0);
    checkOutput("rpt0_run_cnt", bus.run_cnt, 0);
    waitIdle("rpt0_idle_timeout", 10);
    repeat (3) @(negedge clk);

    $display("[TB] abort during second run");
    applyStimulus(3, 1'b0, 1'b0, '{0, 0, 0, 0});
    n = 0;
    while (bus.run_cnt != 8'd1 && n < 300) begin @(negedge clk); n++; end
    checkOutput("abort_reach_run1", bus.run_cnt, 1);
    n = 0;
    while (flick && n < 20) begin @(negedge clk); n++; end
    checkOutput("abort_reach_run_state", flick, 0);
    repeat (3) @(negedge clk);
    checkOutput("abort_busy_before", bus.busy, 1);
    pulseAbort();
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_flick", flick, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_run_cnt", bus.run_cnt, 1);
    checkOutput("abort_cmd_rdy", bus.cmd_rdy, 1);
    clearModel();
    pulseAbort();
    checkOutput("abort_idle_ignored_rdy", bus.cmd_rdy, 1);
    checkOutput("abort_idle_ignored_cnt", bus.run_cnt, 1);

    $display("[TB] stalled lamps");
    applyStimulus(1, 1'b0, 1'b0, '{0, 0, 0, 0});
    n = 0;
    while (flick && n < 20) begin @(negedge clk); n++; end
    checkOutput("stall_reach_run", flick, 0);
    hold_val = 16'h001F;
    hold_en = 1'b1;
`ifdef FLASH_SEQ_WDOG_EN
    waitIdle("stall_wdog_timeout", 120);
    checkOutput("stall_err", bus.err, 1);
    checkOutput("stall_cmd_rdy", bus.cmd_rdy, 1);
`else
    repeat (150) @(negedge clk);
    checkOutput("stall_still_busy", bus.busy, 1);
    checkOutput("stall_err", bus.err, 0);
    pulseAbort();
    checkOutput("stall_abort_busy", bus.busy, 0);
`endif
    clearModel();

    $display("[TB] command after stall");
    applyStimulus(1, 1'b0, 1'b1, '{1, 0, 2, 1});
    checkOutput("recover_err_cleared", bus.err, 0);
    waitIdle("recover_idle_timeout", 200);
    repeat (3) @(negedge clk);

    checkOutput("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
